// File: rtl/fixed_cast_pkg.sv
// fixed_cast_pkg: rounding modes and width/limit helpers shared by the fixed-point cast pipeline
package fixed_cast_pkg;
  typedef enum logic [1:0] {ROUND_FLOOR = 2'd0, ROUND_HALF_UP = 2'd1, ROUND_HALF_EVEN = 2'd2} round_mode_e;
  function automatic int max_i(int a, int b);
    return a > b ? a : b;
  endfunction
  function automatic int calc_w(int in_w, int in_f, int out_w, int out_f);
    return max_i(in_w - in_f, out_w - out_f) + max_i(in_f, out_f) + 2;
  endfunction
  function automatic int calc_d(int in_f, int out_f);
    return in_f - out_f;
  endfunction
  function automatic longint sat_max(int out_w);
    return (longint'(1) << (out_w - 1)) - 1;
  endfunction
  function automatic longint sat_min(int out_w, bit sym);
    return sym ? -sat_max(out_w) : -(longint'(1) << (out_w - 1));
  endfunction
endpackage

// File: rtl/fixed_round_sat.sv
// fixed_round_sat: one lane of align/round (before the S1 register) and clamp (after it)
module fixed_round_sat
  import fixed_cast_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int IN_FRAC_WIDTH  = 8,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 4,
  parameter int ROUND_MODE     = 0,
  parameter int SYMMETRIC_SAT  = 0,
  localparam int W = calc_w(IN_WIDTH, IN_FRAC_WIDTH, OUT_WIDTH, OUT_FRAC_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]  i_data,
  output logic [W-1:0]         o_rounded,
  input  logic [W-1:0]         i_rounded,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_sat
);
  localparam int D = calc_d(IN_FRAC_WIDTH, OUT_FRAC_WIDTH);
  localparam round_mode_e MODE = round_mode_e'(ROUND_MODE);
  localparam logic signed [W-1:0] MAX = W'(sat_max(OUT_WIDTH));
  localparam logic signed [W-1:0] MIN = W'(sat_min(OUT_WIDTH, SYMMETRIC_SAT != 0));
  logic signed [W-1:0] w_ext, w_rnd;
  logic w_hi, w_lo;
  assign w_ext = {{(W - IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data};
  if (D > 0) begin : g_rshift
    localparam logic [D-1:0] H = D'(1) << (D - 1);
    logic signed [W-1:0] w_q;
    logic [D-1:0] w_r;
    logic w_inc;
    assign w_q = w_ext >>> D;
    assign w_r = i_data[D-1:0];
    // W carries two spare bits, so the rounding carry cannot wrap before the clamp sees it
    assign w_inc = MODE == ROUND_HALF_UP ? w_r >= H :
                   MODE == ROUND_HALF_EVEN ? (w_r > H || (w_r == H && w_q[0])) : 1'b0;
    assign w_rnd = w_q + W'(w_inc);
  end else begin : g_lshift
    assign w_rnd = w_ext <<< (-D);
  end
  assign o_rounded = w_rnd;
  assign w_hi = $signed(i_rounded) > MAX;
  assign w_lo = $signed(i_rounded) < MIN;
  assign o_sat = w_hi | w_lo;
  assign o_data = w_hi ? MAX[OUT_WIDTH-1:0] : w_lo ? MIN[OUT_WIDTH-1:0] : i_rounded[OUT_WIDTH-1:0];
endmodule

// File: rtl/fixed_cast_pipe.sv
// fixed_cast_pipe: two-stage streaming fixed-point caster with rounding, saturation and valid/ready backpressure
// `define FIXED_CAST_SAT_CNT_EN adds sat_count/sat_count_clr, a sticky count of beats with any clamped lane
module fixed_cast_pipe
  import fixed_cast_pkg::*;
#(
  parameter int IN_SIZE        = 4,
  parameter int IN_WIDTH       = 16,
  parameter int IN_FRAC_WIDTH  = 8,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 4,
  parameter int ROUND_MODE     = 0,
  parameter int SYMMETRIC_SAT  = 0,
  localparam int W = calc_w(IN_WIDTH, IN_FRAC_WIDTH, OUT_WIDTH, OUT_FRAC_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_SIZE*IN_WIDTH-1:0]  data_in,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic [IN_SIZE*OUT_WIDTH-1:0] data_out,
  output logic                         data_out_valid,
`ifdef FIXED_CAST_SAT_CNT_EN
  output logic [31:0]                  sat_count,
  input  logic                         sat_count_clr,
`endif
  input  logic                         data_out_ready
);
  logic r_v1, r_v2;
  logic [IN_SIZE*W-1:0] r_s1, w_rnd;
  logic [IN_SIZE*OUT_WIDTH-1:0] r_s2, w_sat_data;
  logic [IN_SIZE-1:0] w_sat;
  logic w_adv1, w_adv2;
  assign w_adv2 = ~r_v2 | data_out_ready;
  assign w_adv1 = ~r_v1 | w_adv2;
  assign data_in_ready = w_adv1;
  assign data_out_valid = r_v2;
  assign data_out = r_s2;
  for (genvar i = 0; i < IN_SIZE; i++) begin : g_lane
    fixed_round_sat #(
      .IN_WIDTH(IN_WIDTH), .IN_FRAC_WIDTH(IN_FRAC_WIDTH), .OUT_WIDTH(OUT_WIDTH),
      .OUT_FRAC_WIDTH(OUT_FRAC_WIDTH), .ROUND_MODE(ROUND_MODE), .SYMMETRIC_SAT(SYMMETRIC_SAT)
    ) u_lane (
      .i_data(data_in[i*IN_WIDTH +: IN_WIDTH]),
      .o_rounded(w_rnd[i*W +: W]),
      .i_rounded(r_s1[i*W +: W]),
      .o_data(w_sat_data[i*OUT_WIDTH +: OUT_WIDTH]),
      .o_sat(w_sat[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      if (w_adv1) r_v1 <= data_in_valid;
      if (w_adv1 && data_in_valid) r_s1 <= w_rnd;
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv2 && r_v1) r_s2 <= w_sat_data;
    end
`ifdef FIXED_CAST_SAT_CNT_EN
  logic [31:0] r_sat_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sat_count <= '0;
    else if (sat_count_clr) r_sat_count <= '0;
    else if (w_adv2 && r_v1 && |w_sat && ~&r_sat_count) r_sat_count <= r_sat_count + 32'd1;
  assign sat_count = r_sat_count;
`else
  logic w_unused_sat;
  assign w_unused_sat = |w_sat;
`endif
endmodule

// File: tb/tb_fixed_cast_pipe.sv
// tb_fixed_cast_pipe: random valid/ready stream scored against an arithmetic cast model, plus literal corner cases
module tb_fixed_cast_pipe;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N*16-1:0] data_in = '0;
  logic data_in_valid = 1'b0, data_in_ready, data_out_valid, data_out_ready = 1'b1;
  logic [N*8-1:0] data_out;
  logic [31:0] sat_count;
  logic sat_count_clr = 1'b0;
  int checks = 0, errors = 0;
  logic [N*8-1:0] exp_q [$];
  logic s_valid = 1'b0;
  logic [23:0] m_out [3];
  logic m_valid [3], m_rdy [3];
  logic [7:0] sym_out;
  logic [11:0] up_out;
  logic sym_valid, sym_rdy, up_valid, up_rdy;
  logic [31:0] d_cnt [5];

  always #5 clk = ~clk;

  fixed_cast_pipe u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
`ifdef FIXED_CAST_SAT_CNT_EN
    .sat_count(sat_count), .sat_count_clr(sat_count_clr),
`endif
    .data_out_ready(data_out_ready)
  );

  for (genvar m = 0; m < 3; m++) begin : g_mode
    fixed_cast_pipe #(.IN_SIZE(3), .IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(8), .OUT_FRAC_WIDTH(2), .ROUND_MODE(m))
    u_m (
      .clk(clk), .rst(rst), .data_in(24'hFA0206), .data_in_valid(s_valid), .data_in_ready(m_rdy[m]),
      .data_out(m_out[m]), .data_out_valid(m_valid[m]),
`ifdef FIXED_CAST_SAT_CNT_EN
      .sat_count(d_cnt[m]), .sat_count_clr(1'b0),
`endif
      .data_out_ready(1'b1)
    );
  end

  fixed_cast_pipe #(.IN_SIZE(1), .SYMMETRIC_SAT(1)) u_sym (
    .clk(clk), .rst(rst), .data_in(16'h8000), .data_in_valid(s_valid), .data_in_ready(sym_rdy),
    .data_out(sym_out), .data_out_valid(sym_valid),
`ifdef FIXED_CAST_SAT_CNT_EN
    .sat_count(d_cnt[3]), .sat_count_clr(1'b0),
`endif
    .data_out_ready(1'b1)
  );

  fixed_cast_pipe #(.IN_SIZE(1), .IN_WIDTH(8), .IN_FRAC_WIDTH(2), .OUT_WIDTH(12), .OUT_FRAC_WIDTH(6), .ROUND_MODE(2))
  u_up (
    .clk(clk), .rst(rst), .data_in(8'hF5), .data_in_valid(s_valid), .data_in_ready(up_rdy),
    .data_out(up_out), .data_out_valid(up_valid),
`ifdef FIXED_CAST_SAT_CNT_EN
    .sat_count(d_cnt[4]), .sat_count_clr(1'b0),
`endif
    .data_out_ready(1'b1)
  );

  // Real-valued view: x / 2^in_f rescaled to out_f fraction bits, rounded, then clamped
  function automatic longint cast_ref(longint x, int in_f, int out_w, int out_f, int mode, bit sym);
    longint y, r, h, lim;
    int d = in_f - out_f;
    if (d <= 0) y = x * (longint'(1) << -d);
    else begin
      h = longint'(1) << d;
      y = (x >= 0) ? x / h : -((-x + h - 1) / h);
      r = x - y * h;
      if (mode == 1 && 2 * r >= h) y++;
      else if (mode == 2 && (2 * r > h || (2 * r == h && y % 2 != 0))) y++;
    end
    lim = longint'(1) << (out_w - 1);
    if (y > lim - 1) y = lim - 1;
    if (y < (sym ? 1 - lim : -lim)) y = sym ? 1 - lim : -lim;
    return y;
  endfunction

  function automatic logic [N*8-1:0] exp_beat(logic [N*16-1:0] din);
    logic [N*8-1:0] o;
    for (int i = 0; i < N; i++) o[i*8 +: 8] = 8'(cast_ref(longint'($signed(din[i*16 +: 16])), 8, 8, 4, 0, 1'b0));
    return o;
  endfunction

  function automatic logic [15:0] rand_lane();
    logic [15:0] edges [8] = '{16'h7FFF, 16'h8000, 16'h0780, 16'h07F8, 16'h07F7, 16'hF800, 16'hF808, 16'h0008};
    int s = int'($urandom_range(3));
    if (s == 0) return 16'($urandom);
    if (s == 1) return edges[$urandom_range(7)];
    return 16'($urandom_range(16'h0A00)) - 16'h0500;
  endfunction

  function automatic logic [N*16-1:0] rand_beat();
    logic [N*16-1:0] b;
    for (int i = 0; i < N; i++) b[i*16 +: 16] = rand_lane();
    return b;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic stall_q = 1'b0;
  logic [N*8-1:0] held = '0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", data_out_valid, 1);
        chk("stall_data", data_out, held);
      end
      chk("in_ready", data_in_ready, !(exp_q.size() == 2 && !data_out_ready));
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", data_out_valid, 0);
        else chk("stream", data_out, exp_q.pop_front());
      end
      if (data_in_valid && data_in_ready) exp_q.push_back(exp_beat(data_in));
      stall_q = data_out_valid && !data_out_ready;
      held = data_out;
    end
  end

  initial begin
    int sent, cyc;
    logic acc;
    logic [N*16-1:0] b;
    chk("ref_floor", cast_ref(6, 4, 8, 2, 0, 1'b0), 1);
    chk("ref_half_up", cast_ref(-6, 4, 8, 2, 1, 1'b0), -1);
    chk("ref_half_even", cast_ref(2, 4, 8, 2, 2, 1'b0), 0);
    chk("ref_sym", cast_ref(-32768, 8, 8, 4, 0, 1'b1), -127);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", data_out_valid, 0);
    chk("rst_data", data_out, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    data_in = {16'h0000, 16'h8000, 16'h7FFF, 16'h0180};
    data_in_valid = 1'b1;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    s_valid = 1'b0;
    chk("lat1_valid", data_out_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_valid", data_out_valid, 1);
    chk("t1_data", data_out, 32'h00807F18);
    chk("t2_mode0", m_out[0], 24'hFE0001);
    chk("t2_mode1", m_out[1], 24'hFF0102);
    chk("t2_mode2", m_out[2], 24'hFE0002);
    chk("t2_valid", m_valid[2], 1);
    chk("t1_sym", sym_out, 8'h81);
    chk("t3_shift", up_out, 12'hF50);
`ifdef FIXED_CAST_SAT_CNT_EN
    sat_count_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_count_clr = 1'b0;
    data_in_valid = 1'b1;
    data_in = {16'h7FFF, 16'h0100, 16'h0100, 16'h0100};
    @(posedge clk);
    #1;
    data_in = {4{16'h0100}};
    @(posedge clk);
    #1;
    data_in = {16'h0100, 16'h0100, 16'h0100, 16'h7FFF};
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_count", sat_count, 2);
    data_in = {4{16'h7FFF}};
    data_in_valid = 1'b1;
    sat_count_clr = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    @(posedge clk);
    #1;
    sat_count_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_clr_wins", sat_count, 0);
`endif
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      @(negedge clk);
      acc = data_in_valid && data_in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) sent++;
      if (!data_in_valid || acc) begin
        data_in_valid = sent < 1000 && $urandom_range(9) < 7;
        data_in = rand_beat();
      end
      data_out_ready = $urandom_range(9) < 7;
    end
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    chk("rand_sent", sent, 1000);
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    data_out_ready = 1'b0;
    data_in_valid = 1'b1;
    data_in = rand_beat();
    @(posedge clk);
    #1;
    data_in = rand_beat();
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    chk("pre_rst_valid", data_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", data_out_valid, 0);
    chk("async_rst_data", data_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_out_ready = 1'b1;
    b = {16'hFF80, 16'h0120, 16'h7FFF, 16'h0088};
    data_in = b;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    chk("post_rst_lat1", data_out_valid, 0);
    @(posedge clk);
    #1;
    chk("post_rst_lat2", data_out_valid, 1);
    chk("post_rst_data", data_out, {8'hF8, 8'h12, 8'h7F, 8'h08});
    @(posedge clk);
    #1;
    chk("post_rst_empty", data_out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
